// File: rtl/sum_accumulator.sv
// Windowed accumulator for the registered adder sum.
// It collects N_SAMPLES accepted sums and presents the saturated total on a valid/ready port.
module sum_accumulator #(
    parameter int SUM_W     = 5,
    parameter int ACC_W     = 12,
    parameter int N_SAMPLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       sample_cnt,
    output logic             busy,
    output logic             overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int         EXT_W = ACC_W + 1;
    localparam logic [7:0] LAST  = 8'(N_SAMPLES);

    logic [1:0]       state;
    logic [ACC_W:0]   sum_ext;
    logic [7:0]       cnt_next;
    logic             last_sample;

    // One extra carry bit detects when the true total leaves the ACC_W range.
    assign sum_ext     = {1'b0, acc_out} + EXT_W'(sum_in);
    assign cnt_next    = sample_cnt + 8'd1;
    assign last_sample = (cnt_next == LAST);

    assign busy      = (state == ACCUM);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc_out    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_out    <= '0;
                        sample_cnt <= '0;
                        overflow   <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (sum_ext[ACC_W]) begin
                            acc_out  <= '1;
                            overflow <= 1'b1;
                        end else begin
                            acc_out <= sum_ext[ACC_W-1:0];
                        end
                        sample_cnt <= cnt_next;
                        if (last_sample) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results stay frozen until the consumer takes them.
                    if (out_ready) begin
                        if (start) begin
                            acc_out    <= '0;
                            sample_cnt <= '0;
                            overflow   <= 1'b0;
                            state      <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer for the registered 4-bit adder stage. It takes the 5-bit registered sum and a qualifying valid strobe, and accumulates a fixed number of samples into a wide total. The total is presented on a valid/ready output handshake. It gives the datapath a windowed sum, for example for averaging adder results, without software intervention.

## Interface
- SUM_W, 5: width of incoming sum; matches the adder's 5-bit Sum.
- ACC_W, 12: accumulator width; must be ≥ SUM_W.
- N_SAMPLES, 8: accepted samples per window; legal range 1..255.
- clk  input  1  rising-edge clock; the single clock of the block.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  single-cycle pulse that opens a new accumulation window.
- in_valid  input  1  sum_in is valid this cycle; driven by the adder enable delayed one cycle.
- sum_in  input  SUM_W  unsigned adder result.
- out_ready  input  1  consumer accepts acc_out.
- out_valid  output  1  acc_out holds a completed window total.
- acc_out  output  ACC_W  accumulator register (unsigned).
- sample_cnt  output  8  samples accepted in the current window.
- busy  output  1  high in ACCUM state.
- overflow  output  1  sticky; the window total saturated.

## Operation
- States: IDLE, ACCUM, DONE. Encoding is free.
- IDLE:
  - busy=0, out_valid=0; in_valid is ignored.
  - start=1 → clear acc_out, sample_cnt and overflow; go to ACCUM.
- ACCUM:
  - busy=1.
  - Each cycle with in_valid=1: acc_out ← acc_out + zero-extended sum_in, and sample_cnt ← sample_cnt+1.
  - Gaps in in_valid are allowed and do not advance the count.
  - The accepted sample that brings sample_cnt to N_SAMPLES moves the state to DONE.
  - start is ignored in ACCUM.
- Saturation: if the true sum exceeds 2^ACC_W−1, acc_out is set to all-ones and overflow=1. Further adds keep acc_out at all-ones. overflow holds until the next start or rst.
- DONE:
  - out_valid=1; acc_out, sample_cnt and overflow are frozen; in_valid is ignored.
  - out_valid=1 and out_ready=1 in the same cycle is the handshake → go to IDLE.
  - Handshake and start=1 in the same cycle → go directly to ACCUM with cleared acc_out, sample_cnt and overflow.
  - start without out_ready is ignored.
- acc_out and sample_cnt are visible in every state; consumers qualify them with out_valid.
- rst in any state: IDLE; all outputs 0 (out_valid, busy, overflow, acc_out, sample_cnt). Any partial window is discarded.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- start sampled high at edge t → busy=1 after edge t. The first sample can be accepted at edge t+1.
- Nth sample accepted at edge k → out_valid=1 and busy=0 after edge k, with the final total already on acc_out.
- Minimum window is N_SAMPLES+1 cycles from start to out_valid.
- Handshake at edge h → out_valid=0 after edge h.
- Back-to-back start at edge h → busy=1 after edge h, with no idle cycle.
- out_valid may stay high indefinitely; acc_out must not change while out_valid=1 and out_ready=0.
- rst takes priority over start, in_valid and out_ready in the same cycle.

## Test plan
- Basic window (defaults):
  - Stimulus: start, then 8 consecutive in_valid with sum_in=30.
  - Response: out_valid rises the cycle after the 8th edge; acc_out=240, sample_cnt=8, overflow=0.
- Gapped input:
  - Stimulus: in_valid pattern 1,0,0,1,1,0,1,1,1,1,1 with sum_in=31 on valid cycles.
  - Response: 8 samples accepted, acc_out=248. out_valid rises only after the 8th valid cycle; the invalid cycles leave sample_cnt unchanged.
- Saturation (ACC_W=8, N_SAMPLES=9):
  - Stimulus: 9 samples of 31.
  - Response: after the 9th sample acc_out=255 and overflow=1 (the true total is 279). The next start clears overflow to 0.
- Backpressure:
  - Stimulus: in DONE, hold out_ready=0 for 5 cycles, pulse start, and drive in_valid=1 with sum_in=7.
  - Response: acc_out, sample_cnt and out_valid stay unchanged; no new window starts. out_ready=1 → out_valid=0 next cycle, state IDLE.
- Back-to-back windows:
  - Stimulus: out_ready=1 and start=1 in the same cycle while in DONE.
  - Response: next cycle out_valid=0, busy=1, acc_out=0, sample_cnt=0; the following window accumulates normally.
- Reset mid-window:
  - Stimulus: assert rst after 4 of 8 samples, then deassert.
  - Response: all outputs are 0 the next cycle and the state is IDLE. in_valid without a new start produces no accumulation.
